sample_hex_dumper: RTL and testbench

Multi-channel, parametrised UART dump engine for the DSP correlator debug path. It accepts one command byte from the UART receiver and selects a channel and a mode: either a single live snapshot or a captured burst of DEPTH consecutive samples. It then streams the result to the UART transmitter, as ASCII hex lines or as raw bytes. It sits between the correlator sample bus and the acia_rx/acia_tx byte ports, and replaces the single-byte, single-source dump.

---
 rtl/sample_dump_pkg.sv | 33 +++
 rtl/dump_capture_ram.sv | 37 +++
 rtl/sample_hex_dumper.sv | 225 ++++++++++++++++++++++
 tb/tb_sample_hex_dumper.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_dump_pkg.sv
// +--------------------------------------------------------------------------+
// | sample_dump_pkg : opcodes, FSM states and character constants for the    |
// | sample hex dumper.                          Revision: 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

package sample_dump_pkg;

  localparam logic [3:0] OP_SNAP  = 4'h1;
  localparam logic [3:0] OP_BURST = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CAPT   = 3'd1,
    S_FETCH  = 3'd2,
    S_EMIT   = 3'd3,
    S_GUARD  = 3'd4,
    S_WAITTX = 3'd5
  } state_e;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_ERR = 8'h3F;
  localparam logic [7:0] RAW_ERR  = 8'hFF;

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F' ('A' - 10 = 0x37)
  function automatic logic [7:0] hex2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/dump_capture_ram.sv
// +--------------------------------------------------------------------------+
// | dump_capture_ram : DEPTH x W simple dual-port RAM, registered read port. |
// |                                             Revision: 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

module dump_capture_ram
  import sample_dump_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sample_hex_dumper.sv
// +--------------------------------------------------------------------------+
// | sample_hex_dumper : command-driven snapshot/burst sample dump to UART.   |
// | SAMPLE_HEX_DUMPER_ASCII_EN selects ASCII hex lines; default is raw.      |
// |                                             Revision: 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

module sample_hex_dumper
  import sample_dump_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] smp_dat,
  input  logic             smp_stb,
  input  logic             rx_stb,
  input  logic [7:0]       rx_dat,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_dat,
  output logic             busy,
  output logic             cmd_drop
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              IW      = AW + 1;
  localparam logic [IW-1:0]   DEPTH_I = IW'(DEPTH);
  localparam logic [4:0]      NCH_C   = 5'(NCH);
`ifdef SAMPLE_HEX_DUMPER_ASCII_EN
  localparam int UNIT     = 4;
  localparam int NDIG     = (W + 3) / 4;
  localparam int NCHAR    = NDIG + 2;
  localparam int CW       = $clog2(NDIG + 2);
  localparam int ERR_LAST = 2;
`else
  localparam int UNIT     = 8;
  localparam int NDIG     = (W + 7) / 8;
  localparam int NCHAR    = NDIG;
  localparam int CW       = $clog2(NDIG + 1);
  localparam int ERR_LAST = 0;
`endif
  localparam int SW = UNIT * NDIG;

  function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] d, input logic [3:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (c == 4'(k)) r = d[k*W +: W];
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      ch_q, ch_d;
  logic            burst_q, burst_d;
  logic            err_q, err_d;
  logic [W-1:0]    snap_q, snap_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   wr_q, wr_d;
  logic [IW-1:0]   rd_q, rd_d;
  logic            txs_q, txs_d;
  logic [7:0]      txd_q, txd_d;

  logic            ram_we;
  logic [W-1:0]    cap_dat;
  logic [W-1:0]    rd_dat;
  logic [7:0]      cur_char;
  logic            last_char;
  logic            ch_ok;

  assign cap_dat = pick(smp_dat, ch_q);
  assign ch_ok   = {1'b0, rx_dat[3:0]} < NCH_C;

  // Read address follows the next-state index so the word is registered on
  // the edge entering FETCH and can be loaded into the shifter there.
  dump_capture_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_q[AW-1:0]),
    .wdata (cap_dat),
    .raddr (rd_d[AW-1:0]),
    .rdata (rd_dat)
  );

  always_comb begin
    cur_char = 8'h00;
`ifdef SAMPLE_HEX_DUMPER_ASCII_EN
    if (err_q) begin
      cur_char = (cnt_q == '0) ? CHAR_ERR : (cnt_q == CW'(1)) ? CHAR_CR : CHAR_LF;
    end else if (cnt_q < CW'(NDIG)) begin
      cur_char = hex2asc(sh_q[SW-1 -: 4]);
    end else if (cnt_q == CW'(NDIG)) begin
      cur_char = CHAR_CR;
    end else begin
      cur_char = CHAR_LF;
    end
`else
    cur_char = err_q ? RAW_ERR : sh_q[SW-1 -: 8];
`endif
    last_char = (cnt_q == (err_q ? CW'(ERR_LAST) : CW'(NCHAR - 1)));
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    burst_d = burst_q;
    err_d   = err_q;
    snap_d  = snap_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    txs_d   = 1'b0;
    txd_d   = txd_q;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_stb) begin
          ch_d    = rx_dat[3:0];
          cnt_d   = '0;
          wr_d    = '0;
          rd_d    = '0;
          burst_d = 1'b0;
          err_d   = 1'b0;
          if (ch_ok && rx_dat[7:4] == OP_SNAP) begin
            snap_d  = pick(smp_dat, rx_dat[3:0]);
            state_d = S_FETCH;
          end else if (ch_ok && rx_dat[7:4] == OP_BURST) begin
            burst_d = 1'b1;
            state_d = S_CAPT;
          end else begin
            err_d   = 1'b1;
            state_d = S_EMIT;
          end
        end
      end
      S_CAPT: begin
        if (smp_stb) begin
          ram_we = 1'b1;
          wr_d   = wr_q + 1'b1;
          if (wr_d == DEPTH_I) begin
            rd_d    = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        sh_d    = burst_q ? SW'(rd_dat) : SW'(snap_q);
        cnt_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (!tx_busy) begin
          txs_d   = 1'b1;
          txd_d   = cur_char;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        state_d = S_WAITTX;
      end
      S_WAITTX: begin
        if (!tx_busy) begin
          if (last_char) begin
            if (burst_q) begin
              rd_d    = rd_q + 1'b1;
              state_d = (rd_d == DEPTH_I) ? S_IDLE : S_FETCH;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            sh_d    = sh_q << UNIT;
            state_d = S_EMIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      snap_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      txs_q   <= 1'b0;
      txd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      txs_q   <= txs_d;
      txd_q   <= txd_d;
    end
  end

  assign tx_start = txs_q;
  assign tx_dat   = txd_q;
  assign busy     = (state_q != S_IDLE);
  assign cmd_drop = rx_stb & (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sample_hex_dumper.sv
// +--------------------------------------------------------------------------+
// | tb_sample_hex_dumper : scoreboard bench for sample_hex_dumper.           |
// |                                             Revision: 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sample_hex_dumper;

  localparam int NCH   = 4;
  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam logic [31:0] MASK = 32'h0000_0FFF;
`ifdef SAMPLE_HEX_DUMPER_ASCII_EN
  localparam int ND   = (W + 3) / 4;
  localparam int LINE = ND + 2;
`else
  localparam int NB   = (W + 7) / 8;
  localparam int LINE = NB;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*W-1:0] smp_dat;
  logic             smp_stb;
  logic             rx_stb;
  logic [7:0]       rx_dat;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_dat;
  logic             busy;
  logic             cmd_drop;

  sample_hex_dumper #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smp_dat  (smp_dat),
    .smp_stb  (smp_stb),
    .rx_stb   (rx_stb),
    .rx_dat   (rx_dat),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_dat   (tx_dat),
    .busy     (busy),
    .cmd_drop (cmd_drop)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_q [$];
  int          n_chk, n_pass, n_tx, cyc;
  bit          force_busy;
  logic [31:0] bv [DEPTH+2];
  logic [31:0] v;
  logic [7:0]  saved;
  int          n0;
  bit          hit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, req);
  endtask

  // Reference: digits / bytes derived arithmetically from the sample value.
  task automatic push_line(input logic [31:0] s);
`ifdef SAMPLE_HEX_DUMPER_ASCII_EN
    for (int i = ND - 1; i >= 0; i--) begin
      int n;
      n = int'((s >> (4 * i)) & 32'hF);
      exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
`else
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'((s >> (8 * i)) & 32'hFF));
`endif
  endtask

  task automatic push_err();
`ifdef SAMPLE_HEX_DUMPER_ASCII_EN
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
`else
    exp_q.push_back(8'hFF);
`endif
  endtask

  task automatic set_smp(input int ch, input logic [31:0] s);
    for (int k = 0; k < NCH; k++) smp_dat[k*W +: W] = (k == ch) ? s[W-1:0] : W'($urandom);
  endtask

  task automatic tick();
    @(negedge clk);
    rx_stb  = 1'b0;
    smp_stb = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit drop);
    @(negedge clk);
    rx_dat  = b;
    rx_stb  = 1'b1;
    smp_stb = 1'b0;
    #1 chk("cmd_drop", cmd_drop, drop);
  endtask

  task automatic snap_v(input int ch, input logic [31:0] s);
    send({4'h1, 4'(ch)}, 1'b0);
    set_smp(ch, s);
    push_line(s & MASK);
    tick();
    chk("busy_rise", busy, 1);
    set_smp(-1, 0);
  endtask

  task automatic burst(input int ch, input bit directed);
    logic [31:0] s;
    int gap;
    @(negedge clk);
    set_smp(ch, 32'h0ABC);
    smp_stb = 1'b1;
    send({4'h2, 4'(ch)}, 1'b0);
    set_smp(ch, $urandom);
    smp_stb = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      @(negedge clk);
      rx_stb = 1'b0;
      s = (directed ? bv[i] : $urandom) & MASK;
      set_smp(ch, s);
      smp_stb = 1'b1;
      if (i < DEPTH) push_line(s);
    end
    tick();
  endtask

  task automatic err_cmd(input logic [7:0] b);
    send(b, 1'b0);
    push_err();
    tick();
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  // Transmitter model and scoreboard monitor.
  initial begin
    int bcnt;
    int last;
    bcnt    = 0;
    last    = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bcnt = 0;
      end else if (tx_start) begin
        logic [31:0] req;
        chk("tx_busy_low", tx_busy, 0);
        if (n_tx > 0) chk("tx_spacing", (cyc - last) >= 3, 1);
        if (exp_q.size() > 0) req = {24'h0, exp_q.pop_front()};
        else req = 32'hDEAD_0000;
        chk("tx_byte", tx_dat, req);
        n_tx++;
        last = cyc;
        bcnt = $urandom_range(1, 6);
      end else if (bcnt > 0) begin
        bcnt--;
      end
      tx_busy = force_busy || (bcnt > 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx_stb = 1'b0; rx_dat = 8'h00; smp_stb = 1'b0;
    smp_dat = '0; force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_dat", tx_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_drop", cmd_drop, 0);
    rst_n = 1'b1;

    snap_v(2, 32'hA5C);
    wait_done("snap_a5c");

    bv[0] = 32'h001; bv[1] = 32'h002; bv[2] = 32'hFFF; bv[3] = 32'h800;
    bv[4] = 32'h123; bv[5] = 32'h456;
    burst(1, 1'b1);
    wait_done("burst_directed");

    err_cmd(8'h15); wait_done("err_ch_range");
    err_cmd(8'h31); wait_done("err_opcode");
    err_cmd(8'h00); wait_done("err_op0");

    for (int it = 0; it < 12; it++) begin
      int op, ch;
      op = $urandom_range(0, 3);
      ch = $urandom_range(0, 5);
      if (op == 1 && ch < NCH) snap_v(ch, $urandom);
      else if (op == 2 && ch < NCH) burst(ch, 1'b0);
      else err_cmd({4'(op), 4'(ch)});
      wait_done("random_cmd");
    end

    // Second command while busy is dropped.
    n0 = n_tx;
    snap_v(0, $urandom);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_tx > n0) begin hit = 1'b1; break; end
    end
    chk("drop_first_start", hit, 1);
    send(8'h11, 1'b1);
    tick();
    wait_done("drop_drain");

    // Backpressure.
    force_busy = 1'b1;
    tick(); tick();
    snap_v(3, $urandom);
    n0 = n_tx;
    repeat (4) tick();
    saved = tx_dat;
    repeat (500) tick();
    chk("bp_no_start", n_tx - n0, 0);
    chk("bp_tx_dat", tx_dat, saved);
    chk("bp_busy", busy, 1);
    force_busy = 1'b0;
    wait_done("bp_drain");

    // Reset during the third line of a burst.
    n0 = n_tx;
    burst(1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (n_tx >= n0 + 2 * LINE + 1) begin hit = 1'b1; break; end
    end
    chk("rst_third_line", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_start", tx_start, 0);
    chk("arst_tx_dat", tx_dat, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_drop", cmd_drop, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap_v(0, $urandom);
    wait_done("post_reset_snap");

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
